// File: rtl/button_event_block_if.sv
// Event handshake bundle: one-entry event register to its consumer.
// master: evt_valid/evt_code out, evt_ready in; slave is the reverse.
interface button_event_block_if;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic       evt_ready;

  modport master (
    output evt_valid,
    output evt_code,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_code,
    output evt_ready
  );
endinterface

// File: rtl/button_event_block.sv
// Debounced button level -> PRESS/RELEASE/LONG/REPEAT key events.
// Ports: clk, rst (async high), in (level), evt (event handshake),
// pressed (prev sample), overflow (sticky drop flag), clr_overflow.
module button_event_block #(
  parameter int CNT_WIDTH     = 26,
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000,
  parameter bit REPEAT_EN     = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in,
  button_event_block_if.master evt,
  output logic                 pressed,
  output logic                 overflow,
  input  logic                 clr_overflow
);

  localparam longint CNT_MAX =
    (longint'(1) << CNT_WIDTH) - 1;

  if (LONG_CYCLES < 2) begin : g_bad_long
    $error("LONG_CYCLES must be >= 2");
  end
  if (REPEAT_CYCLES < 2) begin : g_bad_rep
    $error("REPEAT_CYCLES must be >= 2");
  end
  if (longint'(LONG_CYCLES) - 1 > CNT_MAX)
  begin : g_long_fit
    $error("LONG_CYCLES-1 exceeds counter");
  end
  if (longint'(REPEAT_CYCLES) - 1 > CNT_MAX)
  begin : g_rep_fit
    $error("REPEAT_CYCLES-1 exceeds counter");
  end

  localparam logic [CNT_WIDTH-1:0] LONG_TC =
    CNT_WIDTH'(LONG_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] REP_TC =
    CNT_WIDTH'(REPEAT_CYCLES - 1);

  localparam logic [1:0] EV_PRESS   = 2'b00;
  localparam logic [1:0] EV_RELEASE = 2'b01;
  localparam logic [1:0] EV_LONG    = 2'b10;
  localparam logic [1:0] EV_REPEAT  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESSED,
    S_HELD
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic                 prev_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic                 vld_q;
  logic                 vld_d;
  logic [1:0]           code_q;
  logic [1:0]           code_d;
  logic                 ovf_q;
  logic                 ovf_d;

  logic                 rise;
  logic                 fall;
  logic                 new_evt;
  logic [1:0]           new_code;
  logic                 accept;
  logic                 load;
  logic                 drop;

  assign rise = in & ~prev_q;
  assign fall = ~in & prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      code_q  <= EV_PRESS;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= in;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      code_q  <= code_d;
      ovf_q   <= ovf_d;
    end
  end

  // Event FSM; fall is checked first so a release
  // at the terminal edge suppresses LONG/REPEAT.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    new_evt  = 1'b0;
    new_code = EV_PRESS;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (rise) begin
          new_evt  = 1'b1;
          new_code = EV_PRESS;
          state_d  = S_PRESSED;
        end
      end
      S_PRESSED: begin
        if (fall) begin
          new_evt  = 1'b1;
          new_code = EV_RELEASE;
          state_d  = S_IDLE;
          cnt_d    = '0;
        end else if (cnt_q == LONG_TC) begin
          new_evt  = 1'b1;
          new_code = EV_LONG;
          state_d  = S_HELD;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HELD: begin
        if (fall) begin
          new_evt  = 1'b1;
          new_code = EV_RELEASE;
          state_d  = S_IDLE;
          cnt_d    = '0;
        end else if (!REPEAT_EN) begin
          cnt_d = '0;
        end else if (cnt_q == REP_TC) begin
          new_evt  = 1'b1;
          new_code = EV_REPEAT;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // One-entry output register. An accept frees the
  // slot in the same edge, so accept+load is lossless.
  assign accept = vld_q & evt.evt_ready;
  assign load   = new_evt & (~vld_q | evt.evt_ready);
  assign drop   = new_evt & vld_q & ~evt.evt_ready;

  always_comb begin
    vld_d  = vld_q;
    code_d = code_q;
    ovf_d  = ovf_q;
    if (load) begin
      vld_d  = 1'b1;
      code_d = new_code;
    end else if (accept) begin
      vld_d = 1'b0;
    end
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_overflow) begin
      ovf_d = 1'b0;
    end
  end

  assign evt.evt_valid = vld_q;
  assign evt.evt_code  = code_q;
  assign pressed       = prev_q;
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_button_event_block.sv
// Directed bench for button_event_block with an
// expected-event scoreboard checked at each accept.
module tb_button_event_block;

  localparam int LC = 8;
  localparam int RC = 4;
  localparam int CW = 4;

  localparam logic [1:0] C_PRESS   = 2'b00;
  localparam logic [1:0] C_RELEASE = 2'b01;
  localparam logic [1:0] C_LONG    = 2'b10;
  localparam logic [1:0] C_REPEAT  = 2'b11;

  typedef struct {
    logic [1:0] code;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic in0;
  logic in1;
  logic clr0;
  logic clr1;
  logic pressed0;
  logic pressed1;
  logic ovf0;
  logic ovf1;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  exp_t q0[$];
  exp_t q1[$];

  button_event_block_if if0 ();
  button_event_block_if if1 ();

  button_event_block #(
    .CNT_WIDTH    (CW),
    .LONG_CYCLES  (LC),
    .REPEAT_CYCLES(RC),
    .REPEAT_EN    (1'b1)
  ) u0 (
    .clk         (clk),
    .rst         (rst),
    .in          (in0),
    .evt         (if0.master),
    .pressed     (pressed0),
    .overflow    (ovf0),
    .clr_overflow(clr0)
  );

  button_event_block #(
    .CNT_WIDTH    (CW),
    .LONG_CYCLES  (LC),
    .REPEAT_CYCLES(RC),
    .REPEAT_EN    (1'b0)
  ) u1 (
    .clk         (clk),
    .rst         (rst),
    .in          (in1),
    .evt         (if1.master),
    .pressed     (pressed1),
    .overflow    (ovf1),
    .clr_overflow(clr1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic push0(input logic [1:0] c,
                       input int t);
    exp_t e;
    e.code = c;
    e.cyc  = t;
    q0.push_back(e);
  endtask

  task automatic push1(input logic [1:0] c,
                       input int t);
    exp_t e;
    e.code = c;
    e.cyc  = t;
    q1.push_back(e);
  endtask

  // Monitor at negedge, then return at posedge+1
  // where the stimulus drives the next inputs.
  task automatic tick(input int n);
    exp_t e;
    repeat (n) begin
      @(negedge clk);
      if (if0.evt_valid && if0.evt_ready) begin
        if (q0.size() == 0) begin
          chk("d0 spurious evt", q0.size(), 1);
        end else begin
          e = q0.pop_front();
          chk("d0 code", {30'd0, if0.evt_code},
              {30'd0, e.code});
          chk("d0 cycle", cyc, e.cyc);
        end
      end
      if (if1.evt_valid && if1.evt_ready) begin
        if (q1.size() == 0) begin
          chk("d1 spurious evt", q1.size(), 1);
        end else begin
          e = q1.pop_front();
          chk("d1 code", {30'd0, if1.evt_code},
              {30'd0, e.code});
          chk("d1 cycle", cyc, e.cyc);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int c;
    int k;
    rst = 1'b1;
    in0 = 1'b0;
    in1 = 1'b0;
    clr0 = 1'b0;
    clr1 = 1'b0;
    if0.evt_ready = 1'b1;
    if1.evt_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst valid", if0.evt_valid, 0);
    chk("rst code", if0.evt_code, 0);
    chk("rst pressed", pressed0, 0);
    chk("rst overflow", ovf0, 0);
    rst = 1'b0;
    tick(2);

    // short press
    c = cyc;
    in0 = 1'b1;
    push0(C_PRESS, c + 1);
    tick(3);
    in0 = 1'b0;
    push0(C_RELEASE, cyc + 1);
    tick(3);
    chk("short ovf", ovf0, 0);

    // long hold, with and without repeat
    c = cyc;
    k = c + 1;
    in0 = 1'b1;
    in1 = 1'b1;
    push0(C_PRESS, k);
    push0(C_LONG, k + 8);
    push0(C_REPEAT, k + 12);
    push0(C_REPEAT, k + 16);
    push1(C_PRESS, k);
    push1(C_LONG, k + 8);
    tick(20);
    in0 = 1'b0;
    in1 = 1'b0;
    push0(C_RELEASE, cyc + 1);
    push1(C_RELEASE, cyc + 1);
    tick(3);

    // fall at the LONG terminal edge
    c = cyc;
    in0 = 1'b1;
    push0(C_PRESS, c + 1);
    tick(8);
    in0 = 1'b0;
    push0(C_RELEASE, cyc + 1);
    tick(3);

    // backpressure and overflow
    if0.evt_ready = 1'b0;
    in0 = 1'b1;
    tick(3);
    in0 = 1'b0;
    tick(1);
    chk("bp valid", if0.evt_valid, 1);
    chk("bp code", if0.evt_code, C_PRESS);
    chk("bp ovf set", ovf0, 1);
    clr0 = 1'b1;
    tick(1);
    clr0 = 1'b0;
    chk("bp ovf clr", ovf0, 0);
    in0 = 1'b1;
    clr0 = 1'b1;
    tick(1);
    clr0 = 1'b0;
    chk("bp set wins", ovf0, 1);
    chk("bp code hold", if0.evt_code, C_PRESS);
    in0 = 1'b0;
    tick(1);
    clr0 = 1'b1;
    tick(1);
    clr0 = 1'b0;
    chk("bp ovf clr2", ovf0, 0);
    push0(C_PRESS, cyc);
    if0.evt_ready = 1'b1;
    tick(1);
    chk("bp drained", if0.evt_valid, 0);

    // accept and reload at the same edge
    if0.evt_ready = 1'b0;
    in0 = 1'b1;
    tick(2);
    in0 = 1'b0;
    if0.evt_ready = 1'b1;
    push0(C_PRESS, cyc);
    push0(C_RELEASE, cyc + 1);
    tick(1);
    chk("b2b valid", if0.evt_valid, 1);
    chk("b2b code", if0.evt_code, C_RELEASE);
    chk("b2b ovf", ovf0, 0);
    tick(2);
    chk("b2b drained", if0.evt_valid, 0);

    // async reset while held
    c = cyc;
    k = c + 1;
    in0 = 1'b1;
    push0(C_PRESS, k);
    push0(C_LONG, k + 8);
    tick(10);
    if0.evt_ready = 1'b0;
    tick(4);
    chk("held repeat", if0.evt_code, C_REPEAT);
    chk("held pressed", pressed0, 1);
    tick(4);
    chk("held ovf", ovf0, 1);
    rst = 1'b1;
    #1;
    chk("arst valid", if0.evt_valid, 0);
    chk("arst code", if0.evt_code, 0);
    chk("arst pressed", pressed0, 0);
    chk("arst ovf", ovf0, 0);
    tick(2);
    rst = 1'b0;
    if0.evt_ready = 1'b1;
    push0(C_PRESS, cyc + 1);
    push0(C_LONG, cyc + 9);
    tick(10);
    in0 = 1'b0;
    push0(C_RELEASE, cyc + 1);
    tick(3);

    chk("q0 drained", q0.size(), 0);
    chk("q1 drained", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
